screen_compositor: RTL and testbench
====================================

Name: screen_compositor

Overview:
- Parametrised successor to the fixed three-screen colour/font mux at the top of the graphics path.
- Selects one of NUM_SCREENS screen renderers and routes the shared font ROM address from the active renderer.
- Registers the pixel colour and performs frame-synchronised fade-out/fade-in transitions when the game FSM requests a screen change.
- Sits between the screen renderers (start/game/wait/...) and the VGA colour outputs.

Parameters:
- NUM_SCREENS, 3, number of screen renderers; minimum 2.
- SEL_W, $clog2(NUM_SCREENS), width of screen index.
- COLOR_W, 4, bits per colour channel.
- FONT_ADDR_W, 11, font ROM address width.
- LEVEL_W, 3, fade resolution; brightness level ranges 0..2**LEVEL_W.
- FRAMES_PER_STEP, 2, frame_start pulses per fade level step; minimum 1.
- RESET_SCREEN, 0, screen index active after reset.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at DrawX==0, DrawY==0
- video_on  in  1  active-display flag; 0 forces black output
- screen_req  in  SEL_W  requested screen index, level-sampled every cycle
- scr_red  in  NUM_SCREENS*COLOR_W  per-screen red, screen i at bits [i*COLOR_W +: COLOR_W]
- scr_green  in  NUM_SCREENS*COLOR_W  per-screen green, same packing
- scr_blue  in  NUM_SCREENS*COLOR_W  per-screen blue, same packing
- scr_font_addr  in  NUM_SCREENS*FONT_ADDR_W  per-screen font address, same packing
- font_address  out  FONT_ADDR_W  font ROM address of the active screen (combinational from active_screen)
- Red  out  COLOR_W  registered output colour
- Green  out  COLOR_W  registered output colour
- Blue  out  COLOR_W  registered output colour
- active_screen  out  SEL_W  currently displayed screen (registered)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on reset_n.
- Values on reset:
  - state = IDLE, active_screen = RESET_SCREEN, level = 2**LEVEL_W.
  - step counter = 0.
  - Red/Green/Blue = 0, busy = 0.
- Request validity: a screen_req value >= NUM_SCREENS is ignored in every state.
- States:
  - IDLE:
    - A valid screen_req != active_screen latches pending = screen_req and moves to FADE_OUT on the next cycle.
    - Step counter is cleared on entry.
  - FADE_OUT:
    - On each frame_start, the step counter increments.
    - When the counter reaches FRAMES_PER_STEP-1 together with a frame_start, the counter clears and level decrements by 1.
    - When level reaches 0, the FSM moves to SWAP.
    - A valid screen_req that is neither active_screen nor pending updates pending.
    - screen_req == active_screen moves to FADE_IN from the current level (reversal, no swap).
  - SWAP:
    - Lasts exactly one cycle.
    - active_screen <= pending, then the FSM moves to FADE_IN.
    - level stays 0.
  - FADE_IN:
    - Same step timing as FADE_OUT, but level increments.
    - At level == 2**LEVEL_W the FSM moves to IDLE.
    - A valid screen_req != active_screen latches pending and moves to FADE_OUT from the current level.
- Colour path:
  - Latency is 1 cycle from the scr_* colour inputs to Red/Green/Blue.
  - Each channel out <= video_on ? ((c * level) >> LEVEL_W) : 0, where c is the active screen's channel.
  - Product width is COLOR_W+LEVEL_W+1. Truncation is by the shift only; at full level the output equals c exactly.
- font_address is a combinational mux of scr_font_addr by active_screen, so the ROM data returns aligned with the same 1-cycle colour register.
- frame_start in the same cycle as a state entry is counted in the new state.
- reset_n deasserted mid-fade: immediate return to reset values, with no partial fade retained.

Test Plan:
- Reset, RESET_SCREEN=0, screen 0 colours R=F, G=8, B=3, video_on=1 -> one cycle later Red=F, Green=8, Blue=3, busy=0, font_address = screen 0 field.
- screen_req=2, FRAMES_PER_STEP=2, LEVEL_W=3:
  - Required: busy rises the next cycle.
  - Required: level 8->0 after 16 frame_starts, then one SWAP cycle with active_screen=2.
  - Required: full brightness after 16 more frame_starts, busy=0.
  - Required: mid-fade level 4 with c=F -> output 7.
- During FADE_OUT at level 5, screen_req returns to the original screen -> FADE_IN from 5, active_screen never changes, IDLE after 6 more frame_starts.
- screen_req=3 with NUM_SCREENS=3 -> no state change, busy stays 0.
- video_on=0 with screen colours non-zero -> Red/Green/Blue=0 the next cycle while the fade still advances.
- reset_n pulsed low during FADE_IN at level 3 with active_screen=1 -> outputs 0 immediately, active_screen=RESET_SCREEN, IDLE, level 8.

Source files
------------

// File: rtl/screen_compositor.sv
// screen_compositor
//   Selects one of NUM_SCREENS screen renderers, routes the shared font ROM
//   address from the active renderer, registers the output colour, and runs
//   frame-synchronised fade-out / swap / fade-in transitions on a screen
//   change request.
// Ports:
//   clk, reset_n      pixel clock, asynchronous active-low reset
//   frame_start       one-cycle pulse at the top-left pixel
//   video_on          active-display flag, 0 forces black
//   screen_req        requested screen index (level-sampled)
//   scr_red/green/blue, scr_font_addr  packed per-screen renderer outputs
//   font_address      font ROM address of the active screen (combinational)
//   Red, Green, Blue  registered, brightness-scaled colour
//   active_screen     currently displayed screen
//   busy              high while a transition is in progress
module screen_compositor #(
  parameter int unsigned NUM_SCREENS     = 3,
  parameter int unsigned SEL_W           = $clog2(NUM_SCREENS),
  parameter int unsigned COLOR_W         = 4,
  parameter int unsigned FONT_ADDR_W     = 11,
  parameter int unsigned LEVEL_W         = 3,
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned RESET_SCREEN    = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             frame_start,
  input  logic                             video_on,
  input  logic [SEL_W-1:0]                 screen_req,
  input  logic [NUM_SCREENS*COLOR_W-1:0]   scr_red,
  input  logic [NUM_SCREENS*COLOR_W-1:0]   scr_green,
  input  logic [NUM_SCREENS*COLOR_W-1:0]   scr_blue,
  input  logic [NUM_SCREENS*FONT_ADDR_W-1:0] scr_font_addr,
  output logic [FONT_ADDR_W-1:0]           font_address,
  output logic [COLOR_W-1:0]               Red,
  output logic [COLOR_W-1:0]               Green,
  output logic [COLOR_W-1:0]               Blue,
  output logic [SEL_W-1:0]                 active_screen,
  output logic                             busy
);

  localparam int unsigned PROD_W = COLOR_W + LEVEL_W + 1;
  localparam int unsigned CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W:0]   LEVEL_MAX = {1'b1, {LEVEL_W{1'b0}}};
  localparam logic [LEVEL_W:0]   LEVEL_ONE = {{LEVEL_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

  state_t             state;
  logic [SEL_W-1:0]   pending;
  logic [LEVEL_W:0]   level;
  logic [CNT_W-1:0]   step_cnt;

  logic req_valid;
  logic step_done;

  always_comb begin
    req_valid = 32'(screen_req) < NUM_SCREENS;
    step_done = frame_start && (step_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      active_screen <= SEL_W'(RESET_SCREEN);
      pending       <= SEL_W'(RESET_SCREEN);
      level         <= LEVEL_MAX;
      step_cnt      <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          step_cnt <= '0;
          if (req_valid && screen_req != active_screen) begin
            pending <= screen_req;
            state   <= FADE_OUT;
            busy    <= 1'b1;
          end
        end
        FADE_OUT: begin
          // Reversal wins over stepping: brightness resumes rising from here.
          if (req_valid && screen_req == active_screen) begin
            state    <= FADE_IN;
            step_cnt <= '0;
          end else begin
            if (req_valid && screen_req != pending) pending <= screen_req;
            if (level == '0) begin
              state    <= SWAP;
              step_cnt <= '0;
            end else if (frame_start) begin
              if (step_done) begin
                step_cnt <= '0;
                level    <= level - 1'b1;
                if (level == LEVEL_ONE) state <= SWAP;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end
          end
        end
        SWAP: begin
          active_screen <= pending;
          level         <= '0;
          step_cnt      <= '0;
          state         <= FADE_IN;
        end
        FADE_IN: begin
          if (req_valid && screen_req != active_screen) begin
            pending  <= screen_req;
            state    <= FADE_OUT;
            step_cnt <= '0;
          end else if (level == LEVEL_MAX) begin
            state    <= IDLE;
            busy     <= 1'b0;
            step_cnt <= '0;
          end else if (frame_start) begin
            if (step_done) begin
              step_cnt <= '0;
              level    <= level + 1'b1;
              if (level == LEVEL_MAX - LEVEL_ONE) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [LEVEL_W:0]   l);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(l);
    return COLOR_W'(p >> LEVEL_W);
  endfunction

  logic [COLOR_W-1:0] sel_red, sel_green, sel_blue;

  always_comb begin
    sel_red      = scr_red[active_screen*COLOR_W +: COLOR_W];
    sel_green    = scr_green[active_screen*COLOR_W +: COLOR_W];
    sel_blue     = scr_blue[active_screen*COLOR_W +: COLOR_W];
    font_address = scr_font_addr[active_screen*FONT_ADDR_W +: FONT_ADDR_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else if (video_on) begin
      Red   <= scale(sel_red, level);
      Green <= scale(sel_green, level);
      Blue  <= scale(sel_blue, level);
    end else begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end
  end

endmodule

// File: tb/tb_screen_compositor.sv
// tb_screen_compositor
//   Directed-vector bench for screen_compositor with default parameters
//   (3 screens, 4-bit colour, LEVEL_W=3, FRAMES_PER_STEP=2, RESET_SCREEN=0).
//   All screens drive red=F so Red tracks the brightness level directly.
module tb_screen_compositor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        video_on;
  logic [1:0]  screen_req;
  logic [11:0] scr_red, scr_green, scr_blue;
  logic [32:0] scr_font_addr;
  logic [10:0] font_address;
  logic [3:0]  Red, Green, Blue;
  logic [1:0]  active_screen;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Red for c=F at levels 0..8: (15*l)>>3
  int unsigned red_tbl [0:8] = '{0, 1, 3, 5, 7, 9, 11, 13, 15};

  screen_compositor #(
    .NUM_SCREENS(3),
    .COLOR_W(4),
    .FONT_ADDR_W(11),
    .LEVEL_W(3),
    .FRAMES_PER_STEP(2),
    .RESET_SCREEN(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .video_on(video_on),
    .screen_req(screen_req),
    .scr_red(scr_red),
    .scr_green(scr_green),
    .scr_blue(scr_blue),
    .scr_font_addr(scr_font_addr),
    .font_address(font_address),
    .Red(Red),
    .Green(Green),
    .Blue(Blue),
    .active_screen(active_screen),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    frame_start   = 1'b0;
    video_on      = 1'b1;
    screen_req    = 2'd0;
    // screen0: F/8/3, screen1: F/4/9, screen2: F/C/6
    scr_red       = {4'hF, 4'hF, 4'hF};
    scr_green     = {4'hC, 4'h4, 4'h8};
    scr_blue      = {4'h6, 4'h9, 4'h3};
    scr_font_addr = {11'h7AB, 11'h456, 11'h123};

    tick();
    tick();
    check_eq("rst_red", Red, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_active", active_screen, 0);

    reset_n = 1'b1;
    tick();
    check_eq("init_red", Red, 4'hF);
    check_eq("init_green", Green, 4'h8);
    check_eq("init_blue", Blue, 4'h3);
    check_eq("init_busy", busy, 0);
    check_eq("init_font", font_address, 11'h123);

    // Full transition 0 -> 2
    screen_req = 2'd2;
    tick();
    check_eq("req_busy", busy, 1);
    check_eq("req_active", active_screen, 0);
    for (int i = 1; i <= 16; i++) begin
      frame();
      if (i < 16) begin
        tick();
        if (i % 2 == 0) begin
          check_eq("fo_red", Red, red_tbl[8 - i/2]);
          check_eq("fo_green", Green, (8 * (8 - i/2)) >> 3);
        end
        if (i == 8) check_eq("mid_lvl4_red", Red, 7);
      end
    end
    check_eq("preswap_active", active_screen, 0);
    check_eq("preswap_busy", busy, 1);
    tick();
    check_eq("swap_active", active_screen, 2);
    check_eq("swap_red", Red, 0);
    check_eq("swap_font", font_address, 11'h7AB);
    for (int i = 1; i <= 16; i++) begin
      frame();
      if (i < 16) begin
        tick();
        if (i % 2 == 0) begin
          check_eq("fi_red", Red, red_tbl[i/2]);
          check_eq("fi_green", Green, (12 * (i/2)) >> 3);
        end
        check_eq("fi_busy", busy, 1);
      end
    end
    check_eq("fi_done_busy", busy, 0);
    tick();
    check_eq("full_red", Red, 4'hF);
    check_eq("full_green", Green, 4'hC);
    check_eq("full_blue", Blue, 4'h6);

    // Reversal at level 5
    screen_req = 2'd0;
    tick();
    check_eq("rev_busy", busy, 1);
    for (int i = 1; i <= 6; i++) begin
      frame();
      tick();
    end
    check_eq("rev_lvl5_red", Red, 9);
    screen_req = 2'd2;
    tick();
    check_eq("rev_hold_red", Red, 9);
    for (int i = 1; i <= 6; i++) begin
      frame();
      if (i == 5) check_eq("rev_busy5", busy, 1);
      check_eq("rev_active", active_screen, 2);
      tick();
    end
    check_eq("rev_done_busy", busy, 0);
    check_eq("rev_red", Red, 4'hF);
    check_eq("rev_green", Green, 4'hC);

    // Out-of-range request ignored
    screen_req = 2'd3;
    tick();
    tick();
    tick();
    check_eq("inv_busy", busy, 0);
    check_eq("inv_active", active_screen, 2);

    // Blanking while fading 2 -> 1
    screen_req = 2'd1;
    tick();
    video_on = 1'b0;
    frame();
    tick();
    frame();
    tick();
    check_eq("blank_red", Red, 0);
    check_eq("blank_green", Green, 0);
    check_eq("blank_blue", Blue, 0);
    video_on = 1'b1;
    tick();
    check_eq("unblank_red", Red, 13);
    for (int i = 1; i <= 14; i++) begin
      frame();
      tick();
    end
    check_eq("swap1_active", active_screen, 1);
    for (int i = 1; i <= 6; i++) begin
      frame();
      tick();
    end
    check_eq("lvl3_red", Red, 5);
    check_eq("lvl3_green", Green, 1);
    check_eq("lvl3_active", active_screen, 1);

    // Asynchronous reset mid-fade
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_red", Red, 0);
    check_eq("arst_green", Green, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_active", active_screen, 0);
    check_eq("arst_font", font_address, 11'h123);
    screen_req = 2'd0;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_red", Red, 4'hF);
    check_eq("post_rst_green", Green, 4'h8);
    check_eq("post_rst_blue", Blue, 4'h3);
    tick();
    check_eq("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
